// File: rtl/rx_cmd_ctrl.sv
// Command decoder between a UART RX byte stream, a register file, an ALU and a TX FIFO.
// Every output is a register fed from the next-state logic, so no input reaches an output combinationally.
module rx_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   output logic                    WrEn,
   output logic                    RdEn,
   output logic [ADDR_WIDTH-1:0]   Address,
   output logic [DATA_WIDTH-1:0]   WrData,
   input  logic [DATA_WIDTH-1:0]   RdData,
   input  logic                    RdData_Valid,
   output logic                    ALU_EN,
   output logic [3:0]              ALU_FUN,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    OUT_Valid,
   output logic                    CLK_GATE_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    FIFO_FULL
);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
      ALU_OP, ALU_WAIT, TX_LO, TX_HI
   } state_t;

   localparam logic [DATA_WIDTH-1:0] C_REG_WR  = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] C_REG_RD  = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] C_ALU_OP  = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] C_ALU_NOP = DATA_WIDTH'(8'hDD);

   state_t                  r_state,       w_state_next;
   logic                    r_wr_en,       w_wr_en_next;
   logic                    r_rd_en,       w_rd_en_next;
   logic [ADDR_WIDTH-1:0]   r_address,     w_address_next;
   logic [DATA_WIDTH-1:0]   r_wr_data,     w_wr_data_next;
   logic                    r_alu_en,      w_alu_en_next;
   logic [3:0]              r_alu_fun,     w_alu_fun_next;
   logic                    r_clk_gate_en, w_clk_gate_en_next;
   logic [DATA_WIDTH-1:0]   r_tx_data,     w_tx_data_next;
   logic                    r_tx_vld,      w_tx_vld_next;
   logic [2*DATA_WIDTH-1:0] r_result,      w_result_next;
   logic                    r_two_bytes,   w_two_bytes_next;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state       <= IDLE;
         r_wr_en       <= 1'b0;
         r_rd_en       <= 1'b0;
         r_address     <= '0;
         r_wr_data     <= '0;
         r_alu_en      <= 1'b0;
         r_alu_fun     <= '0;
         r_clk_gate_en <= 1'b0;
         r_tx_data     <= '0;
         r_tx_vld      <= 1'b0;
         r_result      <= '0;
         r_two_bytes   <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_wr_en       <= w_wr_en_next;
         r_rd_en       <= w_rd_en_next;
         r_address     <= w_address_next;
         r_wr_data     <= w_wr_data_next;
         r_alu_en      <= w_alu_en_next;
         r_alu_fun     <= w_alu_fun_next;
         r_clk_gate_en <= w_clk_gate_en_next;
         r_tx_data     <= w_tx_data_next;
         r_tx_vld      <= w_tx_vld_next;
         r_result      <= w_result_next;
         r_two_bytes   <= w_two_bytes_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_wr_en_next     = 1'b0;
      w_rd_en_next     = 1'b0;
      w_address_next   = r_address;
      w_wr_data_next   = r_wr_data;
      w_alu_fun_next   = r_alu_fun;
      w_tx_data_next   = r_tx_data;
      w_tx_vld_next    = 1'b0;
      w_result_next    = r_result;
      w_two_bytes_next = r_two_bytes;

      case (r_state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == C_REG_WR)       w_state_next = WR_ADDR;
               else if (RX_P_DATA == C_REG_RD)  w_state_next = RD_ADDR;
               else if (RX_P_DATA == C_ALU_OP)  w_state_next = OP_A;
               else if (RX_P_DATA == C_ALU_NOP) w_state_next = ALU_OP;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               w_address_next = RX_P_DATA[ADDR_WIDTH-1:0];
               w_state_next   = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               w_wr_en_next   = 1'b1;
               w_wr_data_next = RX_P_DATA;
               w_state_next   = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               w_rd_en_next   = 1'b1;
               w_address_next = RX_P_DATA[ADDR_WIDTH-1:0];
               w_state_next   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (RdData_Valid) begin
               w_result_next    = {{DATA_WIDTH{1'b0}}, RdData};
               w_two_bytes_next = 1'b0;
               w_tx_data_next   = RdData;
               w_state_next     = TX_LO;
            end
         end
         OP_A: begin
            if (RX_D_VLD) begin
               w_wr_en_next   = 1'b1;
               w_address_next = ADDR_WIDTH'(0);
               w_wr_data_next = RX_P_DATA;
               w_state_next   = OP_B;
            end
         end
         OP_B: begin
            if (RX_D_VLD) begin
               w_wr_en_next   = 1'b1;
               w_address_next = ADDR_WIDTH'(1);
               w_wr_data_next = RX_P_DATA;
               w_state_next   = ALU_OP;
            end
         end
         ALU_OP: begin
            if (RX_D_VLD) begin
               w_alu_fun_next = RX_P_DATA[3:0];
               w_state_next   = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            if (OUT_Valid) begin
               w_result_next    = ALU_OUT;
               w_two_bytes_next = 1'b1;
               w_tx_data_next   = ALU_OUT[DATA_WIDTH-1:0];
               w_state_next     = TX_LO;
            end
         end
         // The push strobe lands one cycle later, together with the data staged here.
         TX_LO: begin
            if (!FIFO_FULL) begin
               w_tx_vld_next  = 1'b1;
               w_tx_data_next = r_result[DATA_WIDTH-1:0];
               w_state_next   = r_two_bytes ? TX_HI : IDLE;
            end
         end
         TX_HI: begin
            if (!FIFO_FULL) begin
               w_tx_vld_next  = 1'b1;
               w_tx_data_next = r_result[2*DATA_WIDTH-1:DATA_WIDTH];
               w_state_next   = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase

      // Derived from the next state so the registered copies line up with the state register.
      w_alu_en_next      = (w_state_next == ALU_WAIT);
      w_clk_gate_en_next = (w_state_next == ALU_OP) || (w_state_next == ALU_WAIT);
   end

   assign WrEn        = r_wr_en;
   assign RdEn        = r_rd_en;
   assign Address     = r_address;
   assign WrData      = r_wr_data;
   assign ALU_EN      = r_alu_en;
   assign ALU_FUN     = r_alu_fun;
   assign CLK_GATE_EN = r_clk_gate_en;
   assign TX_P_DATA   = r_tx_data;
   assign TX_D_VLD    = r_tx_vld;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Bench for rx_cmd_ctrl: directed command scenarios followed by random command traffic,
// checked against a transaction-level model of register-file writes/reads and TX pushes.
module tb_rx_cmd_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [DW-1:0] RX_P_DATA = '0;
   logic          RX_D_VLD = 1'b0;
   logic          WrEn, RdEn;
   logic [AW-1:0] Address;
   logic [DW-1:0] WrData;
   logic [DW-1:0] RdData = '0;
   logic          RdData_Valid = 1'b0;
   logic          ALU_EN;
   logic [3:0]    ALU_FUN;
   logic [2*DW-1:0] ALU_OUT = '0;
   logic          OUT_Valid = 1'b0;
   logic          CLK_GATE_EN;
   logic [DW-1:0] TX_P_DATA;
   logic          TX_D_VLD;
   logic          FIFO_FULL = 1'b0;

   rx_cmd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
      .RdData(RdData), .RdData_Valid(RdData_Valid),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
      .CLK_GATE_EN(CLK_GATE_EN),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
   );

   always #5 CLK = ~CLK;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;
   int collisions = 0;

   // model_mem: what the bench believes the register file holds; env_mem: the file the bench emulates.
   logic [7:0]  model_mem [16];
   logic [7:0]  env_mem   [16];
   logic [11:0] wr_q[$], exp_wr[$];
   logic [3:0]  rd_q[$], exp_rd[$];
   logic [7:0]  tx_q[$], exp_tx[$];
   logic [3:0]  last_rd_addr = '0;

   always @(posedge CLK) begin
      #1;
      if (WrEn) begin
         wr_q.push_back({Address, WrData});
         env_mem[Address] = WrData;
      end
      if (RdEn) begin
         rd_q.push_back(Address);
         last_rd_addr = Address;
      end
      if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
      if (WrEn && RdEn) collisions++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return 32'({WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, TX_P_DATA, TX_D_VLD});
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge CLK);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   task automatic start_txn();
      wr_q.delete(); rd_q.delete(); tx_q.delete();
      exp_wr.delete(); exp_rd.delete(); exp_tx.delete();
   endtask

   task automatic finish_txn(input string tag, input int n_tx);
      int k = 0;
      while (tx_q.size() < n_tx && k < 60) begin
         @(negedge CLK);
         k++;
      end
      check($sformatf("%s_tx_timeout", tag), 32'(tx_q.size() >= n_tx), 32'(1));
      repeat (4) @(negedge CLK);
      check($sformatf("%s_wr_count", tag), 32'(wr_q.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size(); i++)
         if (i < wr_q.size()) check($sformatf("%s_wr%0d", tag, i), 32'(wr_q[i]), 32'(exp_wr[i]));
      check($sformatf("%s_rd_count", tag), 32'(rd_q.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size(); i++)
         if (i < rd_q.size()) check($sformatf("%s_rd%0d", tag, i), 32'(rd_q[i]), 32'(exp_rd[i]));
      check($sformatf("%s_tx_count", tag), 32'(tx_q.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size(); i++)
         if (i < tx_q.size()) check($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      start_txn();
      send_byte(8'hAA);
      send_byte(a);
      send_byte(d);
      model_mem[a[3:0]] = d;
      exp_wr.push_back({a[3:0], d});
      finish_txn("write", 0);
   endtask

   task automatic do_read(input logic [7:0] a, input int delay, input int stall);
      start_txn();
      send_byte(8'hBB);
      send_byte(a);
      exp_rd.push_back(a[3:0]);
      exp_tx.push_back(model_mem[a[3:0]]);
      repeat (delay) @(negedge CLK);
      RdData       = env_mem[last_rd_addr];
      RdData_Valid = 1'b1;
      FIFO_FULL    = (stall > 0);
      @(negedge CLK);
      RdData_Valid = 1'b0;
      RdData       = 8'($urandom);
      if (stall > 0) begin
         repeat (stall) @(negedge CLK);
         check("read_stall_nopush", 32'(tx_q.size()), 32'(0));
      end
      FIFO_FULL = 1'b0;
      finish_txn("read", 1);
   endtask

   task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] fun, input bit stray, input int delay,
                         input int stall, input logic [15:0] result);
      start_txn();
      if (with_ops) begin
         send_byte(8'hCC);
         send_byte(a);
         send_byte(b);
         model_mem[0] = a;
         model_mem[1] = b;
         exp_wr.push_back({4'd0, a});
         exp_wr.push_back({4'd1, b});
      end else begin
         send_byte(8'hDD);
      end
      check("gate_in_alu_op", 32'(CLK_GATE_EN), 32'(1));
      check("alu_en_before_fun", 32'(ALU_EN), 32'(0));
      send_byte(fun);
      check("alu_en_wait", 32'(ALU_EN), 32'(1));
      check("alu_fun", 32'(ALU_FUN), 32'(fun[3:0]));
      check("gate_in_alu_wait", 32'(CLK_GATE_EN), 32'(1));
      if (stray) begin
         send_byte(8'hAA);
         check("stray_alu_en", 32'(ALU_EN), 32'(1));
         check("stray_alu_fun", 32'(ALU_FUN), 32'(fun[3:0]));
         check("stray_gate", 32'(CLK_GATE_EN), 32'(1));
      end
      repeat (delay) @(negedge CLK);
      check("gate_before_valid", 32'(CLK_GATE_EN), 32'(1));
      ALU_OUT   = result;
      OUT_Valid = 1'b1;
      FIFO_FULL = (stall > 0);
      @(negedge CLK);
      OUT_Valid = 1'b0;
      ALU_OUT   = 16'($urandom);
      check("alu_en_after_valid", 32'(ALU_EN), 32'(0));
      check("gate_after_valid", 32'(CLK_GATE_EN), 32'(0));
      if (stall > 0) begin
         repeat (stall) @(negedge CLK);
         check("alu_stall_nopush", 32'(tx_q.size()), 32'(0));
         check("alu_stall_vld", 32'(TX_D_VLD), 32'(0));
         check("alu_stall_hold", 32'(TX_P_DATA), 32'(result[7:0]));
      end
      FIFO_FULL = 1'b0;
      exp_tx.push_back(result[7:0]);
      exp_tx.push_back(result[15:8]);
      finish_txn("alu", 2);
   endtask

   initial begin
      logic [7:0] noise;
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 8'($urandom);
         env_mem[i]   = model_mem[i];
      end
      model_mem[7] = 8'h5A;
      env_mem[7]   = 8'h5A;

      repeat (3) @(negedge CLK);
      check("reset_outputs", all_outs(), 32'(0));
      RST = 1'b1;

      // Directed scenarios
      do_write(8'h05, 8'h3C);
      do_read(8'h07, 2, 0);
      do_alu(1'b1, 8'h12, 8'h34, 8'h02, 1'b0, 2, 0, 16'h0368);
      do_alu(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1, 5, 16'hA55A);

      start_txn();
      send_byte(8'h77);
      repeat (4) @(negedge CLK);
      check("idle_ignore_strobes", 32'({WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD}), 32'(0));
      check("idle_ignore_wr", 32'(wr_q.size()), 32'(0));
      do_write(8'h09, 8'hC3);

      do_alu(1'b0, 8'h00, 8'h00, 8'h0B, 1'b1, 3, 0, 16'h1234);

      start_txn();
      send_byte(8'hAA);
      send_byte(8'h03);
      check("addr_before_reset", 32'(Address), 32'(3));
      RST = 1'b0;
      #1;
      check("midcmd_reset_outputs", all_outs(), 32'(0));
      @(negedge CLK);
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset_no_write", 32'(wr_q.size()), 32'(0));
      do_write(8'h01, 8'hFF);

      // Random traffic
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 3) == 0) begin
            noise = 8'($urandom);
            while (noise == 8'hAA || noise == 8'hBB || noise == 8'hCC || noise == 8'hDD)
               noise = 8'($urandom);
            send_byte(noise);
         end
         case ($urandom_range(0, 3))
            0: do_write(8'($urandom), 8'($urandom));
            1: do_read(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
            2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
                      $urandom_range(0, 4), $urandom_range(0, 3), 16'($urandom));
            default: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 1'($urandom),
                            $urandom_range(0, 4), $urandom_range(0, 3), 16'($urandom));
         endcase
      end

      check("wr_rd_collisions", 32'(collisions), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
